// File: rtl/adc_ser_pkg.sv
// adc_ser_pkg: shared constants, beat type and FSM states for the ADC channel serializer
package adc_ser_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W = 3;
  localparam int DROP_CNT_W = 16;
  localparam int DATA_W = 24;
  typedef logic [NUM_CH-1:0][DATA_W-1:0] beat_t;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/adc_beat_fifo.sv
// adc_beat_fifo: synchronous beat FIFO with registered storage; push+pop while full is legal
module adc_beat_fifo
  import adc_ser_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter type T = beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  T     wr_data,
  output T     rd_data,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = clr ? '0 : wr_q + (AW+1)'(push);
    rd_d = clr ? '0 : rd_q + (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q[AW-1:0]] <= wr_data;
  end
  assign rd_data = mem_q[rd_q[AW-1:0]];
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// File: rtl/adc_channel_serializer.sv
// adc_channel_serializer: buffers 8-channel beats and emits them as a channel-interleaved stream
// with frame marker; define ADC_SER_DROP_CNT_EN to add the saturating drop_cnt port.
module adc_channel_serializer
  import adc_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FRAME_LEN = 512,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] sd_0,
  input  logic [DATA_WIDTH-1:0] sd_1,
  input  logic [DATA_WIDTH-1:0] sd_2,
  input  logic [DATA_WIDTH-1:0] sd_3,
  input  logic [DATA_WIDTH-1:0] sd_4,
  input  logic [DATA_WIDTH-1:0] sd_5,
  input  logic [DATA_WIDTH-1:0] sd_6,
  input  logic [DATA_WIDTH-1:0] sd_7,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CH_W-1:0]       m_chan,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  overflow
`ifdef ADC_SER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);
  localparam int SW = $clog2(FRAME_LEN);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  typedef logic [NUM_CH-1:0][DATA_WIDTH-1:0] hold_t;
  hold_t in_beat, fifo_out, hold_q, hold_d;
  state_t state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d, m_chan_q, m_chan_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic m_valid_q, m_valid_d, m_last_q, m_last_d, overflow_q, overflow_d;
  logic full, empty, push, pop, drop, hs;
  assign in_beat = {sd_7, sd_6, sd_5, sd_4, sd_3, sd_2, sd_1, sd_0};
  adc_beat_fifo #(.DEPTH(FIFO_DEPTH), .T(hold_t)) u_fifo (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
    .wr_data(in_beat), .rd_data(fifo_out), .full(full), .empty(empty)
  );
  // A pop on the ch7 handshake frees a slot, so a push into a full FIFO is accepted then.
  always_comb begin
    hs = state_q == SEND && m_ready;
    pop = !clr && !empty && (state_q == IDLE || (hs && ch_q == LAST_CH));
    push = !clr && in_valid && (!full || pop);
    drop = !clr && in_valid && full && !pop;
    state_d = state_q;
    ch_d = ch_q;
    samp_d = samp_q;
    hold_d = pop ? fifo_out : hold_q;
    if (clr) begin
      state_d = IDLE;
      ch_d = '0;
      samp_d = '0;
    end else if (state_q == IDLE) begin
      state_d = pop ? SEND : IDLE;
      ch_d = '0;
    end else if (hs) begin
      ch_d = ch_q == LAST_CH ? '0 : ch_q + CH_W'(1);
      samp_d = ch_q == LAST_CH ? samp_q + SW'(1) : samp_q;
      state_d = (ch_q != LAST_CH || pop) ? SEND : IDLE;
    end
    overflow_d = clr ? 1'b0 : overflow_q | drop;
    m_valid_d = state_d == SEND;
    m_chan_d = ch_d;
    m_data_d = hold_d[ch_d];
    m_last_d = m_valid_d && ch_d == LAST_CH && samp_d == SW'(FRAME_LEN - 1);
  end
`ifdef ADC_SER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  always_comb drop_cnt_d = clr ? '0 : (drop && drop_cnt_q != '1) ? drop_cnt_q + DROP_CNT_W'(1) : drop_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  end
  assign drop_cnt = drop_cnt_q;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q <= '0;
      samp_q <= '0;
      hold_q <= '0;
      m_data_q <= '0;
      m_chan_q <= '0;
      m_valid_q <= 1'b0;
      m_last_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      samp_q <= samp_d;
      hold_q <= hold_d;
      m_data_q <= m_data_d;
      m_chan_q <= m_chan_d;
      m_valid_q <= m_valid_d;
      m_last_q <= m_last_d;
      overflow_q <= overflow_d;
    end
  end
  assign m_data = m_data_q;
  assign m_chan = m_chan_q;
  assign m_valid = m_valid_q;
  assign m_last = m_last_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_adc_channel_serializer.sv
// tb_adc_channel_serializer: directed table and sequence checks with FRAME_LEN=4, FIFO_DEPTH=8
module tb_adc_channel_serializer;
  logic clk = 0;
  logic rst = 1;
  logic clr = 0;
  logic in_valid = 0;
  logic m_ready = 0;
  logic [23:0] sd [8];
  logic [23:0] m_data;
  logic [2:0] m_chan;
  logic m_valid, m_last, overflow;
  int checks = 0;
  int errors = 0;
`ifdef ADC_SER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  adc_channel_serializer #(.DATA_WIDTH(24), .FRAME_LEN(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .sd_0(sd[0]), .sd_1(sd[1]), .sd_2(sd[2]), .sd_3(sd[3]),
    .sd_4(sd[4]), .sd_5(sd[5]), .sd_6(sd[6]), .sd_7(sd[7]),
    .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .overflow(overflow)
`ifdef ADC_SER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv;
    logic rdy;
    logic ev;
    logic [2:0] ech;
    logic [23:0] ed;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beats(input int nb, input logic [23:0] base);
    for (int b = 0; b < nb; b++) begin
      in_valid = 1;
      for (int k = 0; k < 8; k++) sd[k] = base + 24'(b * 16 + k);
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic stream(input int nb, input logic [23:0] base, input bit tog, input int samp0,
                        input int skip, input int inj_n, input logic [23:0] inj_base);
    int n = 0;
    int cyc = 0;
    int b;
    logic [23:0] ed;
    while (n < nb * 8 && cyc < 600) begin
      m_ready = tog ? cyc[0] : 1'b1;
      in_valid = 0;
      if (m_valid) begin
        b = n / 8;
        if (b >= skip) b++;
        ed = base + 24'(b * 16 + n % 8);
        chk("s_chan", 32'(m_chan), n % 8);
        chk("s_data", 32'(m_data), 32'(ed));
        chk("s_last", 32'(m_last), 32'(((samp0 + n / 8) % 4 == 3) && (n % 8 == 7)));
        if (m_ready) begin
          if (n == inj_n) begin
            in_valid = 1;
            for (int k = 0; k < 8; k++) sd[k] = inj_base + 24'(k);
          end
          n++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 0;
    chk("s_count", n, nb * 8);
    chk("s_drain", 32'(m_valid), 0);
  endtask

  task automatic wait_ch3();
    for (int i = 0; i < 50; i++) begin
      if (m_valid && m_chan == 3) break;
      @(negedge clk);
    end
    chk("reach_ch3", 32'(m_chan), 3);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) sd[k] = '0;
    vecs[0] = '{1, 1, 0, 0, 0};
    for (int i = 1; i <= 8; i++) vecs[i] = '{0, 1, 1, 3'(i - 1), 24'h100000 + 24'(i - 1)};
    vecs[9] = '{0, 1, 0, 0, 0};
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_chan", 32'(m_chan), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_ovf", 32'(overflow), 0);
`ifdef ADC_SER_DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt), 0);
`endif
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].iv;
      m_ready = vecs[i].rdy;
      for (int k = 0; k < 8; k++) sd[k] = 24'h100000 + 24'(k);
      @(negedge clk);
      chk("t_valid", 32'(m_valid), 32'(vecs[i].ev));
      chk("t_last", 32'(m_last), 0);
      if (vecs[i].ev) begin
        chk("t_chan", 32'(m_chan), 32'(vecs[i].ech));
        chk("t_data", 32'(m_data), 32'(vecs[i].ed));
      end
    end
    in_valid = 0;
    clr = 1;
    @(negedge clk);
    clr = 0;
    // two full frames of 4 beats: m_last on 32nd sample of each
    m_ready = 0;
    push_beats(4, 24'h200000);
    stream(4, 24'h200000, 0, 0, 99, -1, 0);
    m_ready = 0;
    push_beats(4, 24'h210000);
    stream(4, 24'h210000, 0, 0, 99, -1, 0);
    // hold reg + 8 FIFO slots absorb 9 beats; the 10th is dropped
    m_ready = 0;
    push_beats(9, 24'h300000);
    chk("ovf_before", 32'(overflow), 0);
    push_beats(1, 24'h300090);
    chk("ovf_after", 32'(overflow), 1);
`ifdef ADC_SER_DROP_CNT_EN
    chk("drop_one", 32'(drop_cnt), 1);
`endif
    stream(10, 24'h300000, 0, 0, 9, 7, 24'h3000A0);
    chk("ovf_sticky", 32'(overflow), 1);
`ifdef ADC_SER_DROP_CNT_EN
    chk("drop_still_one", 32'(drop_cnt), 1);
`endif
    m_ready = 0;
    push_beats(1, 24'h400000);
    stream(1, 24'h400000, 1, 2, 99, -1, 0);
    // clr mid-beat flushes FIFO, counters and the sticky flag
    m_ready = 0;
    push_beats(10, 24'h450000);
    chk("ovf_pre_clr", 32'(overflow), 1);
    m_ready = 1;
    wait_ch3();
    clr = 1;
    in_valid = 1;
    @(negedge clk);
    clr = 0;
    in_valid = 0;
    chk("clr_valid", 32'(m_valid), 0);
    chk("clr_chan", 32'(m_chan), 0);
    chk("clr_ovf", 32'(overflow), 0);
`ifdef ADC_SER_DROP_CNT_EN
    chk("clr_drop", 32'(drop_cnt), 0);
`endif
    repeat (3) @(negedge clk);
    chk("clr_flushed", 32'(m_valid), 0);
    m_ready = 0;
    push_beats(4, 24'h500000);
    stream(4, 24'h500000, 0, 0, 99, -1, 0);
    // async reset mid-frame
    m_ready = 0;
    push_beats(10, 24'h600000);
    chk("ovf_pre_rst", 32'(overflow), 1);
    m_ready = 1;
    wait_ch3();
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(m_valid), 0);
    chk("arst_data", 32'(m_data), 0);
    chk("arst_chan", 32'(m_chan), 0);
    chk("arst_last", 32'(m_last), 0);
    chk("arst_ovf", 32'(overflow), 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("arst_empty", 32'(m_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
